// File: rtl/fft_peak_finder_pkg.sv
// Shared constants for the FFT peak finder: data field layout, tag layout and FSM encoding.
package fft_peak_finder_pkg;

  localparam int DATA_WIDTH_DEF = 24;
  localparam int RE_LSB         = 0;
  localparam int IM_LSB         = 24;
  localparam int USER_WIDTH     = 16;

  // Sideband tag = {valid, first, last, in_range, err, k}; flag offsets sit above k.
  localparam int TAG_FLAGS  = 5;
  localparam int TAG_ERR    = 0;
  localparam int TAG_INRNG  = 1;
  localparam int TAG_LAST   = 2;
  localparam int TAG_FIRST  = 3;
  localparam int TAG_VALID  = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

endpackage

// File: rtl/fft_peak_finder_if.sv
// FFT output stream as seen by the passive peak-finder tap.
interface fft_peak_finder_if
  import fft_peak_finder_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
  logic [2*DATA_WIDTH-1:0] fft_tdata;
  logic                    fft_tvalid;
  logic                    fft_tlast;
  logic [USER_WIDTH-1:0]   fft_tuser;

  modport master (output fft_tdata, output fft_tvalid, output fft_tlast, output fft_tuser);
  modport slave  (input  fft_tdata, input  fft_tvalid, input  fft_tlast, input  fft_tuser);
endinterface

// File: rtl/fft_peak_finder_cmag_sq.sv
// Two-stage exact |re + j*im|^2 pipeline with a pass-through tag of arbitrary width.
module fft_peak_finder_cmag_sq #(
  parameter int DATA_WIDTH = 24,
  parameter int TAG_WIDTH  = 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic signed [DATA_WIDTH-1:0] i_re,
  input  logic signed [DATA_WIDTH-1:0] i_im,
  input  logic [TAG_WIDTH-1:0]         i_tag,
  output logic [2*DATA_WIDTH-1:0]      o_sq,
  output logic [TAG_WIDTH-1:0]         o_tag
);

  logic signed [DATA_WIDTH-1:0]   w_lane [2];
  logic signed [2*DATA_WIDTH-1:0] r_lane_sq [2];
  logic [TAG_WIDTH-1:0]           r_tag_s1;
  logic [TAG_WIDTH-1:0]           r_tag_s2;
  logic [2*DATA_WIDTH-1:0]        r_sq;

  assign w_lane[0] = i_re;
  assign w_lane[1] = i_im;

  // Each square is non-negative and at most 2^(2*DATA_WIDTH-2), so the signed product never wraps.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          r_lane_sq[gi] <= '0;
        end else begin
          r_lane_sq[gi] <= w_lane[gi] * w_lane[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_tag_s1 <= '0;
      r_tag_s2 <= '0;
      r_sq     <= '0;
    end else begin
      r_tag_s1 <= i_tag;
      r_tag_s2 <= r_tag_s1;
      r_sq     <= $unsigned(r_lane_sq[0]) + $unsigned(r_lane_sq[1]);
    end
  end

  assign o_sq  = r_sq;
  assign o_tag = r_tag_s2;

endmodule

// File: rtl/fft_peak_finder.sv
// Passive FFT stream tap: finds the strongest positive-frequency bin of each frame and reports it.
module fft_peak_finder
  import fft_peak_finder_pkg::*;
#(
  parameter int ADDR_WIDTH = 11,
  parameter int K_MIN      = 2,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                    clock,
  input  logic                    reset,
  fft_peak_finder_if.slave        fft,
  output logic [ADDR_WIDTH-1:0]   k_max,
  output logic                    k_max_valid,
  output logic [2*DATA_WIDTH-1:0] peak_mag,
  output logic                    frame_err
);

  localparam int                TAG_W   = ADDR_WIDTH + TAG_FLAGS;
  localparam int                CNT_W   = ADDR_WIDTH + 2;
  localparam logic [CNT_W-1:0]  N_BEATS = CNT_W'(1) << ADDR_WIDTH;
  localparam logic [CNT_W-1:0]  CNT_SAT = N_BEATS + CNT_W'(1);

  state_t                  r_state;
  state_t                  w_state_next;
  logic [CNT_W-1:0]        r_beat_cnt;
  logic [CNT_W-1:0]        w_cnt_next;
  logic [CNT_W-1:0]        w_cnt_now;
  logic                    w_first;
  logic                    w_last;
  logic [ADDR_WIDTH-1:0]   w_k;
  logic                    w_in_range;
  logic [TAG_W-1:0]        w_tag_in;
  logic [TAG_W-1:0]        w_tag_s2;
  logic [2*DATA_WIDTH-1:0] w_sq_s2;

  logic [2*DATA_WIDTH-1:0] r_max_mag;
  logic [ADDR_WIDTH-1:0]   r_max_k;
  logic                    r_seen;
  logic [2*DATA_WIDTH-1:0] w_base_mag;
  logic [ADDR_WIDTH-1:0]   w_base_k;
  logic                    w_base_seen;
  logic                    w_upd;
  logic [2*DATA_WIDTH-1:0] w_new_mag;
  logic [ADDR_WIDTH-1:0]   w_new_k;
  logic                    w_new_seen;
  logic                    w_s_valid;
  logic                    w_s_report;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_beat_cnt <= w_cnt_next;
    end
  end

  // w_cnt_now is the frame length including the current beat; it saturates so oversize frames stay flagged.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_beat_cnt;
    w_first      = 1'b0;
    w_last       = 1'b0;
    w_cnt_now    = (r_beat_cnt == CNT_SAT) ? CNT_SAT : r_beat_cnt + CNT_W'(1);
    if (r_state == IDLE) begin
      w_cnt_now = CNT_W'(1);
    end
    if (fft.fft_tvalid) begin
      w_first = (r_state == IDLE);
      if (fft.fft_tlast) begin
        w_last       = 1'b1;
        w_state_next = IDLE;
        w_cnt_next   = '0;
      end else begin
        w_state_next = ACCUM;
        w_cnt_next   = w_cnt_now;
      end
    end
  end

  assign w_k        = fft.fft_tuser[ADDR_WIDTH-1:0];
  assign w_in_range = (w_k >= ADDR_WIDTH'(K_MIN)) && !w_k[ADDR_WIDTH-1];
  assign w_tag_in   = {fft.fft_tvalid, w_first, w_last, w_in_range, (w_cnt_now != N_BEATS), w_k};

  fft_peak_finder_cmag_sq #(
    .DATA_WIDTH (DATA_WIDTH),
    .TAG_WIDTH  (TAG_W)
  ) u_cmag_sq (
    .clock (clock),
    .reset (reset),
    .i_re  (fft.fft_tdata[RE_LSB +: DATA_WIDTH]),
    .i_im  (fft.fft_tdata[IM_LSB +: DATA_WIDTH]),
    .i_tag (w_tag_in),
    .o_sq  (w_sq_s2),
    .o_tag (w_tag_s2)
  );

  // A first-tagged beat starts from an empty max, so the previous frame never leaks into this one.
  always_comb begin
    w_s_valid   = w_tag_s2[ADDR_WIDTH + TAG_VALID];
    w_s_report  = w_s_valid && w_tag_s2[ADDR_WIDTH + TAG_LAST];
    w_base_mag  = r_max_mag;
    w_base_k    = r_max_k;
    w_base_seen = r_seen;
    if (w_tag_s2[ADDR_WIDTH + TAG_FIRST]) begin
      w_base_mag  = '0;
      w_base_k    = '0;
      w_base_seen = 1'b0;
    end
    w_upd      = w_s_valid && w_tag_s2[ADDR_WIDTH + TAG_INRNG] &&
                 (!w_base_seen || (w_sq_s2 > w_base_mag));
    w_new_mag  = w_upd ? w_sq_s2 : w_base_mag;
    w_new_k    = w_upd ? w_tag_s2[ADDR_WIDTH-1:0] : w_base_k;
    w_new_seen = w_base_seen || w_upd;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_max_mag   <= '0;
      r_max_k     <= '0;
      r_seen      <= 1'b0;
      k_max       <= '0;
      k_max_valid <= 1'b0;
      peak_mag    <= '0;
      frame_err   <= 1'b0;
    end else begin
      k_max_valid <= w_s_report;
      if (w_s_valid) begin
        r_max_mag <= w_new_mag;
        r_max_k   <= w_new_k;
        r_seen    <= w_new_seen;
      end
      if (w_s_report) begin
        k_max     <= w_new_k;
        peak_mag  <= w_new_mag;
        frame_err <= w_tag_s2[ADDR_WIDTH + TAG_ERR];
      end
    end
  end

endmodule

// File: tb/tb_fft_peak_finder.sv
// Directed and randomized frames checked against a per-frame peak model.
module tb_fft_peak_finder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] k_max;
  logic        k_max_valid;
  logic [47:0] peak_mag;
  logic        frame_err;

  always #5 clock = ~clock;

  fft_peak_finder_if #(.DATA_WIDTH(24)) bus();

  fft_peak_finder #(
    .ADDR_WIDTH (11),
    .K_MIN      (2),
    .DATA_WIDTH (24)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .fft         (bus),
    .k_max       (k_max),
    .k_max_valid (k_max_valid),
    .peak_mag    (peak_mag),
    .frame_err   (frame_err)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int     obs_cyc[$];
  int     obs_k[$];
  longint obs_mag[$];
  int     obs_err[$];
  int     exp_cyc[$];
  int     exp_k[$];
  longint exp_mag[$];
  int     exp_err[$];

  int fr_re[2048];
  int fr_im[2048];
  int fr_k[2048];

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (k_max_valid) begin
      obs_cyc.push_back(cyc);
      obs_k.push_back(int'(k_max));
      obs_mag.push_back(longint'(peak_mag));
      obs_err.push_back(int'(frame_err));
      $display("report cycle=%0d k_max=%0d peak_mag=%0d frame_err=%0d", cyc, k_max, peak_mag, frame_err);
    end
  end

  task automatic chk(input string tag, input longint obs, input longint expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock); #1;
      bus.fft_tvalid = 1'b0;
      bus.fft_tlast  = 1'b0;
      bus.fft_tdata  = 48'({$urandom(), $urandom()});
      bus.fft_tuser  = 16'($urandom());
    end
  endtask

  task automatic drive_beat(input int i, input bit last);
    @(posedge clock); #1;
    bus.fft_tvalid = 1'b1;
    bus.fft_tlast  = last;
    bus.fft_tdata  = {24'(fr_im[i]), 24'(fr_re[i])};
    bus.fft_tuser  = {5'($urandom()), 11'(fr_k[i])};
  endtask

  function automatic longint mag(input int i);
    longint re, im;
    re = fr_re[i];
    im = fr_im[i];
    return re * re + im * im;
  endfunction

  function automatic int rnd24();
    return int'($urandom_range(16777215, 0)) - 8388608;
  endfunction

  task automatic fill(input int len, input int re, input int im);
    for (int i = 0; i < len; i++) begin
      fr_k[i]  = i;
      fr_re[i] = re;
      fr_im[i] = im;
    end
  endtask

  task automatic fill_random(input int len);
    for (int i = 0; i < len; i++) begin
      fr_k[i]  = i;
      fr_re[i] = rnd24();
      fr_im[i] = rnd24();
    end
  endtask

  // Expected report: strongest in-range bin, earliest beat wins a tie; nothing in range gives 0/0.
  task automatic run_frame(input int len, input int gap_pct);
    longint best;
    int     ek;
    best = -1;
    ek   = 0;
    for (int i = 0; i < len; i++) begin
      if (fr_k[i] >= 2 && fr_k[i] < 1024 && mag(i) > best) begin
        best = mag(i);
        ek   = fr_k[i];
      end
    end
    for (int i = 0; i < len; i++) begin
      while (gap_pct > 0 && int'($urandom_range(99, 0)) < gap_pct) idle(1);
      drive_beat(i, i == len - 1);
    end
    exp_cyc.push_back(cyc + 3);
    exp_k.push_back(ek);
    exp_mag.push_back(best < 0 ? 64'd0 : best);
    exp_err.push_back(len != 2048 ? 1 : 0);
  endtask

  task automatic check_reports(input string tag);
    for (int w = 0; w < 12 && obs_cyc.size() < exp_cyc.size(); w++) idle(1);
    idle(3);
    chk($sformatf("%s_count", tag), obs_cyc.size(), exp_cyc.size());
    while (obs_cyc.size() > 0 && exp_cyc.size() > 0) begin
      chk($sformatf("%s_cycle", tag), obs_cyc.pop_front(), exp_cyc.pop_front());
      chk($sformatf("%s_k", tag),     obs_k.pop_front(),   exp_k.pop_front());
      chk($sformatf("%s_mag", tag),   obs_mag.pop_front(), exp_mag.pop_front());
      chk($sformatf("%s_err", tag),   obs_err.pop_front(), exp_err.pop_front());
    end
    obs_cyc.delete(); obs_k.delete(); obs_mag.delete(); obs_err.delete();
    exp_cyc.delete(); exp_k.delete(); exp_mag.delete(); exp_err.delete();
  endtask

  initial begin
    bus.fft_tvalid = 1'b0;
    bus.fft_tlast  = 1'b0;
    bus.fft_tdata  = '0;
    bus.fft_tuser  = '0;

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_k", k_max, 0);
    chk("rst_valid", k_max_valid, 0);
    chk("rst_mag", peak_mag, 0);
    chk("rst_err", frame_err, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    idle(4);

    // 1: single strong bin in a uniform floor
    fill(2048, 10, 10);
    fr_re[100] = 1000; fr_im[100] = 0;
    run_frame(2048, 0);
    check_reports("t1");
    chk("t1_k_const", k_max, 100);
    chk("t1_mag_const", peak_mag, 1000000);

    // 2: tie keeps the lower bin
    fill(2048, 0, 0);
    fr_re[50] = 300; fr_im[50] = -400;
    fr_re[70] = 300; fr_im[70] = -400;
    run_frame(2048, 0);
    check_reports("t2");
    chk("t2_k_const", k_max, 50);
    chk("t2_mag_const", peak_mag, 250000);

    // 3: DC and negative-frequency bins are ignored
    fill(2048, 0, 0);
    fr_re[0] = 8388607; fr_re[1500] = 5000; fr_re[10] = 20;
    run_frame(2048, 0);
    check_reports("t3");
    chk("t3_k_const", k_max, 10);

    // 4: back-to-back frames with no idle cycle
    fill(2048, 1, 1);
    fr_re[7] = 700;
    run_frame(2048, 0);
    fill(2048, 1, 1);
    fr_im[900] = -900;
    run_frame(2048, 0);
    check_reports("t4");
    chk("t4_k_const", k_max, 900);

    // 5: short frame with random gaps
    fill_random(1000);
    run_frame(1000, 30);
    check_reports("t5");
    chk("t5_err_const", frame_err, 1);

    // Random full frame with gaps, then a 1-beat frame
    fill_random(2048);
    run_frame(2048, 10);
    check_reports("trand");
    fr_k[0] = 5; fr_re[0] = 123; fr_im[0] = -7;
    run_frame(1, 0);
    check_reports("t1beat");

    // 6: reset mid-frame discards the partial frame
    fill_random(2048);
    for (int i = 0; i < 600; i++) drive_beat(i, 1'b0);
    @(posedge clock); #1;
    reset = 1'b1;
    bus.fft_tvalid = 1'b0;
    @(negedge clock);
    chk("t6_rst_k", k_max, 0);
    chk("t6_rst_mag", peak_mag, 0);
    chk("t6_rst_err", frame_err, 0);
    chk("t6_rst_valid", k_max_valid, 0);
    idle(2);
    reset = 1'b0;
    idle(6);
    chk("t6_no_pulse", obs_cyc.size(), 0);
    fill(2048, 3, 4);
    fr_re[333] = -2000; fr_im[333] = 1500;
    run_frame(2048, 0);
    check_reports("t6");
    chk("t6_k_const", k_max, 333);

    // 7: most negative components, exact 2^47
    fill(2048, 0, 0);
    fr_re[3] = -8388608; fr_im[3] = -8388608;
    run_frame(2048, 0);
    check_reports("t7");
    chk("t7_mag_const", peak_mag, 64'h0000_8000_0000_0000);
    chk("t7_k_const", k_max, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
